// File: rtl/processor_trace_buffer_pkg.sv
// Shared types for the processor trace buffer: FSM states, capture modes
// and the packed entry width used by the storage array.
package processor_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READOUT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  typedef enum logic {
    MODE_FILL = 1'b0,
    MODE_WRAP = 1'b1
  } mode_e;

  // Entry layout is {operand channels, instruction, pc}, pc in the LSBs.
  function automatic int unsigned entry_width(input int unsigned xlen, input int unsigned nch);
    return xlen + 32 + nch * xlen;
  endfunction

endpackage

// File: rtl/processor_trace_buffer_if.sv
// Capture bus from the core and valid/ready readout port of the trace buffer.
interface processor_trace_buffer_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NCH  = 2
);
  logic                  cap_valid;
  logic [XLEN-1:0]       cap_pc;
  logic [31:0]           cap_instr;
  logic [NCH*XLEN-1:0]   cap_ch;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [XLEN-1:0]       rd_pc;
  logic [31:0]           rd_instr;
  logic [NCH*XLEN-1:0]   rd_ch;
  logic                  rd_last;

  modport master (
    output cap_valid, cap_pc, cap_instr, cap_ch, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_ch, rd_last
  );

  modport slave (
    input  cap_valid, cap_pc, cap_instr, cap_ch, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_ch, rd_last
  );
endinterface

// File: rtl/processor_trace_buffer_ram.sv
// Trace storage: flop array with one synchronous write and one
// asynchronous read port; contents are not reset.
module trace_ram #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned W     = 128,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/processor_trace_buffer.sv
// Per-cycle execution trace capture (FILL or circular WRAP with trigger and
// post-trigger window, cycle-limit timeout) drained over a valid/ready port.
module processor_trace_buffer
  import processor_trace_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned NCH         = 2,
  parameter int unsigned CYCLE_LIMIT = 400
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arm,
  input  logic                       mode,
  input  logic                       trigger,
  processor_trace_buffer_if.slave    bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [1:0]                 state,
  output logic                       done,
  output logic                       timeout
);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH+1);
  localparam int unsigned EW   = entry_width(XLEN, NCH);
  localparam int unsigned CW   = (CYCLE_LIMIT > 1) ? $clog2(CYCLE_LIMIT+1) : 1;

  state_e          st;
  mode_e           md;
  logic [PW-1:0]   wr_ptr, rd_ptr, post_cnt;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   cyc_cnt;
  logic            post_armed;
  logic [EW-1:0]   rd_entry;

  logic            wr_en, limit_hit, end_cap;
  logic [PW-1:0]   wr_ptr_nx;
  logic [CNTW-1:0] cnt_nx;

  assign wr_en     = (st == ST_CAPTURE) && bus.cap_valid;
  assign limit_hit = (st == ST_CAPTURE) && (CYCLE_LIMIT != 0) && (cyc_cnt == CW'(CYCLE_LIMIT - 1));

  // Next pointer/count are also used to seed rd_ptr on the edge capture ends,
  // so the entry written on that same edge is included in the readout.
  always_comb begin
    wr_ptr_nx = wr_ptr;
    cnt_nx    = cnt;
    end_cap   = 1'b0;
    if (wr_en) begin
      wr_ptr_nx = wr_ptr + PW'(1);
      if (cnt != CNTW'(DEPTH)) cnt_nx = cnt + CNTW'(1);
    end
    if (md == MODE_FILL)
      end_cap = trigger || (cnt_nx == CNTW'(DEPTH));
    else
      end_cap = post_armed && wr_en && (post_cnt == PW'(DEPTH/2 - 1));
    if (limit_hit) end_cap = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      md         <= MODE_FILL;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      post_cnt   <= '0;
      cnt        <= '0;
      cyc_cnt    <= '0;
      post_armed <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (st)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            st         <= ST_CAPTURE;
            md         <= mode_e'(mode);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            post_cnt   <= '0;
            cnt        <= '0;
            cyc_cnt    <= '0;
            post_armed <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          wr_ptr  <= wr_ptr_nx;
          cnt     <= cnt_nx;
          cyc_cnt <= cyc_cnt + CW'(1);
          // The trigger-cycle write is the trigger entry, not a post entry.
          if (md == MODE_WRAP) begin
            if (!post_armed && trigger) post_armed <= 1'b1;
            else if (post_armed && wr_en) post_cnt <= post_cnt + PW'(1);
          end
          if (limit_hit) timeout <= 1'b1;
          if (end_cap) begin
            st     <= ST_READOUT;
            rd_ptr <= wr_ptr_nx - PW'(cnt_nx);
          end
        end
        ST_READOUT: begin
          if (cnt == '0) begin
            st <= ST_DONE;
          end else if (bus.rd_ready) begin
            rd_ptr <= rd_ptr + PW'(1);
            cnt    <= cnt - CNTW'(1);
            if (cnt == CNTW'(1)) st <= ST_DONE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({bus.cap_ch, bus.cap_instr, bus.cap_pc}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign bus.rd_valid = (st == ST_READOUT) && (cnt != '0);
  assign bus.rd_last  = (st == ST_READOUT) && (cnt == CNTW'(1));
  assign bus.rd_pc    = rd_entry[XLEN-1:0];
  assign bus.rd_instr = rd_entry[XLEN +: 32];
  assign bus.rd_ch    = rd_entry[XLEN+32 +: NCH*XLEN];
  assign count        = cnt;
  assign state        = st;
  assign done         = (st == ST_DONE);
endmodule

// File: tb/tb_processor_trace_buffer.sv
// Randomized bench for processor_trace_buffer against a queue-based model
// of the capture/readout rules, plus directed FILL/WRAP/timeout scenarios.
module tb_processor_trace_buffer;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NCH   = 2;
  localparam int unsigned LIMIT = 400;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [63:0] ch;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n, arm, mode, trigger;
  logic [4:0] count;
  logic [1:0] state;
  logic       done, timeout;

  processor_trace_buffer_if #(.XLEN(XLEN), .NCH(NCH)) bus ();

  processor_trace_buffer #(
    .XLEN        (XLEN),
    .DEPTH       (DEPTH),
    .NCH         (NCH),
    .CYCLE_LIMIT (LIMIT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arm     (arm),
    .mode    (mode),
    .trigger (trigger),
    .bus     (bus),
    .count   (count),
    .state   (state),
    .done    (done),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   dut_xfers = 0;
  logic prev_valid = 1'b0;

  // Reference model: phase 0 idle, 1 capture, 2 readout, 3 done.
  int   m_st = 0;
  bit   m_mode, m_trig, m_to;
  int   m_cyc, m_post;
  ent_t m_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    ent_t e;
    bit   fin;
    if (!rst_n) begin
      m_st = 0; m_to = 0; m_q.delete();
      return;
    end
    case (m_st)
      0, 3: if (arm) begin
        m_st = 1; m_mode = mode; m_q.delete();
        m_cyc = 0; m_post = 0; m_trig = 0; m_to = 0;
      end
      1: begin
        fin = 0;
        if (bus.cap_valid) begin
          e.pc = bus.cap_pc; e.instr = bus.cap_instr; e.ch = bus.cap_ch;
          m_q.push_back(e);
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
        end
        m_cyc++;
        if (!m_mode) begin
          if (m_q.size() == DEPTH || trigger) fin = 1;
        end else if (m_trig) begin
          if (bus.cap_valid) begin
            m_post++;
            if (m_post == DEPTH/2) fin = 1;
          end
        end else if (trigger) begin
          m_trig = 1;
        end
        if (m_cyc == LIMIT) begin fin = 1; m_to = 1; end
        if (fin) m_st = 2;
      end
      2: begin
        if (m_q.size() == 0) m_st = 3;
        else if (bus.rd_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_st = 3;
        end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic compare();
    bit ev;
    ev = (m_st == 2) && (m_q.size() > 0);
    check("state", 64'(state), 64'(m_st));
    check("count", 64'(count), 64'(m_q.size()));
    check("done", 64'(done), 64'(m_st == 3));
    check("timeout", 64'(timeout), 64'(m_to));
    check("rd_valid", 64'(bus.rd_valid), 64'(ev));
    if (ev) begin
      check("rd_pc", 64'(bus.rd_pc), 64'(m_q[0].pc));
      check("rd_instr", 64'(bus.rd_instr), 64'(m_q[0].instr));
      check("rd_ch", bus.rd_ch, m_q[0].ch);
      check("rd_last", 64'(bus.rd_last), 64'(m_q.size() == 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (prev_valid && bus.rd_ready) dut_xfers++;
    model_step();
    #1;
    compare();
    prev_valid = bus.rd_valid;
  endtask

  task automatic do_arm(input logic m);
    arm = 1'b1; mode = m;
    tick();
    arm = 1'b0;
  endtask

  task automatic put(input logic [31:0] pc, input logic trig);
    bus.cap_valid = 1'b1;
    bus.cap_pc    = pc;
    bus.cap_instr = $urandom;
    bus.cap_ch    = {$urandom, $urandom};
    trigger       = trig;
    tick();
    bus.cap_valid = 1'b0;
    trigger       = 1'b0;
  endtask

  task automatic drain(input int bound, input bit toggle);
    for (int k = 0; k < bound && m_st != 3; k++) begin
      bus.rd_ready = toggle ? k[0] : 1'b1;
      tick();
    end
    bus.rd_ready = 1'b0;
    check("drain_done", 64'(state), 64'(3));
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; mode = 1'b0; trigger = 1'b0;
    bus.cap_valid = 1'b0; bus.cap_pc = '0; bus.cap_instr = '0; bus.cap_ch = '0;
    bus.rd_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset held two cycles in the middle of a capture.
    do_arm(1'b0);
    for (int i = 0; i < 5; i++) put(32'(i * 4), 1'b0);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_state", 64'(state), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    tick();

    // FILL: 20 back-to-back captures, only the first 16 kept.
    dut_xfers = 0;
    do_arm(1'b0);
    for (int i = 0; i < 20; i++) put(32'(i * 4), 1'b0);
    check("fill_first_pc", 64'(bus.rd_pc), 64'(0));
    drain(40, 1'b0);
    check("fill_xfers", 64'(dut_xfers), 64'(16));

    // WRAP: trigger on entry 30, stops after 8 post entries.
    dut_xfers = 0;
    do_arm(1'b1);
    for (int i = 0; i < 40; i++) put(32'(i * 4), i == 30);
    check("wrap_first_pc", 64'(bus.rd_pc), 64'h5C);
    drain(40, 1'b0);
    check("wrap_xfers", 64'(dut_xfers), 64'(16));

    // Timeout with no captures.
    dut_xfers = 0;
    do_arm(1'b1);
    for (int k = 0; k < LIMIT + 10 && m_st != 3; k++) tick();
    check("to_flag", 64'(timeout), 64'(1));
    check("to_state", 64'(state), 64'(3));
    check("to_xfers", 64'(dut_xfers), 64'(0));

    // Backpressure on a full FILL buffer.
    dut_xfers = 0;
    do_arm(1'b0);
    for (int i = 0; i < 16; i++) put(32'h100 + 32'(i * 4), 1'b0);
    drain(80, 1'b1);
    check("bp_xfers", 64'(dut_xfers), 64'(16));

    // Reset after 5 transfers, then a clean re-arm.
    dut_xfers = 0;
    do_arm(1'b0);
    for (int i = 0; i < 16; i++) put(32'h200 + 32'(i * 4), 1'b0);
    bus.rd_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    bus.rd_ready = 1'b0;
    check("mid_xfers", 64'(dut_xfers), 64'(5));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_state", 64'(state), 64'(0));
    dut_xfers = 0;
    do_arm(1'b0);
    for (int i = 0; i < 16; i++) put(32'h300 + 32'(i * 4), 1'b0);
    drain(40, 1'b0);
    check("rearm_xfers", 64'(dut_xfers), 64'(16));

    // Random traffic: gaps, sparse triggers, stray arms, random backpressure.
    for (int r = 0; r < 6; r++) begin
      do_arm(1'($urandom));
      for (int k = 0; k < 300; k++) begin
        bus.cap_valid = ($urandom % 4) != 0;
        bus.cap_pc    = $urandom;
        bus.cap_instr = $urandom;
        bus.cap_ch    = {$urandom, $urandom};
        trigger       = ($urandom % 40) == 0;
        arm           = ($urandom % 50) == 0;
        mode          = 1'($urandom);
        bus.rd_ready  = 1'($urandom);
        tick();
      end
      arm = 1'b0; trigger = 1'b0;
      for (int k = 0; k < 500 && m_st != 3; k++) begin
        bus.cap_valid = 1'($urandom);
        bus.cap_pc    = $urandom;
        bus.rd_ready  = 1'($urandom);
        tick();
      end
      bus.cap_valid = 1'b0; bus.rd_ready = 1'b0;
      check("rand_done", 64'(done), 64'(1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/processor_trace_buffer.md
# processor_trace_buffer

Synthesisable per-cycle execution trace capture for the single-cycle processor: records PC, instruction and NCH register-operand values (rs1, rs2, ...) into a DEPTH-entry buffer, then drains them over a valid/ready port. Sits beside the processor core, fed from its internal pc/instruction/operand nets. Adds fill and circular-with-trigger capture modes, a post-trigger window and a cycle-limit timeout. Usable in simulation and on hardware without a display/dump facility.

## Interface
- XLEN, 32, width of PC and operand values
- DEPTH, 16, buffer entries; power of two, >= 4
- NCH, 2, operand channels captured per entry
- CYCLE_LIMIT, 400, capture cycles before forced stop; 0 disables
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- arm  in  1  start capture (honoured in IDLE/DONE only)
- mode  in  1  0 = FILL (stop when full), 1 = WRAP (circular, trigger-stopped); sampled on arm
- trigger  in  1  FILL: early stop; WRAP: start post-trigger window
- cap_valid  in  1  capture entry this cycle
- cap_pc  in  XLEN  PC of entry
- cap_instr  in  32  instruction word
- cap_ch  in  NCH*XLEN  operand values, channel 0 in LSBs
- rd_valid  out  1  readout entry available
- rd_ready  in  1  consumer accepts entry
- rd_pc, rd_instr, rd_ch  out  XLEN/32/NCH*XLEN  oldest unread entry
- rd_last  out  1  current entry is final one
- count  out  $clog2(DEPTH+1)  valid entries held
- state  out  2  IDLE=0, CAPTURE=1, READOUT=2, DONE=3
- done  out  1  high in DONE
- timeout  out  1  sticky: capture ended by CYCLE_LIMIT

## Operation
- Reset: state IDLE, count 0, pointers 0, cycle counter 0, timeout 0, rd_valid 0, rd_last 0, done 0; buffer contents don't-care.
- IDLE/DONE + arm: -> CAPTURE; latch mode; clear count, pointers, cycle counter, post counter, timeout. Arm elsewhere ignored.
- CAPTURE, FILL: cap_valid writes at wr_ptr, wr_ptr++, count++. Write that makes count==DEPTH -> READOUT. trigger -> READOUT with current count (entry written that same cycle is kept).
- CAPTURE, WRAP: writes wrap modulo DEPTH; count saturates at DEPTH (oldest overwritten). First trigger arms post window; entry written on trigger cycle is the trigger entry, not post. After DEPTH/2 further writes -> READOUT. Later triggers ignored.
- Cycle counter increments every CAPTURE cycle; reaching CYCLE_LIMIT (non-zero) -> READOUT, timeout=1. Coincident write still accepted.
- Captures outside CAPTURE dropped.
- READOUT: rd_ptr = wr_ptr - count (mod DEPTH) on entry. rd_valid = (count>0). Transfer on rd_valid&&rd_ready: rd_ptr++, count--. rd_last = (count==1). After last transfer -> DONE; entering READOUT with count 0 -> DONE next cycle, rd_valid never asserted.
- rd_* outputs stable while rd_valid && !rd_ready.

## Timing
- Write visible in count the cycle after cap_valid.
- End condition at edge N -> state READOUT from edge N+1; rd_valid may assert same cycle (rd data read combinationally from buffer at rd_ptr).
- One transfer per cycle max; full drain of DEPTH entries with rd_ready held high takes DEPTH cycles, then DONE next cycle.
- rst_n low at any edge (including mid-capture/mid-readout) -> reset values next cycle; contents discarded.

## Structure
- Package processor_trace_pkg: state enum (IDLE/CAPTURE/READOUT/DONE), mode enum (FILL/WRAP), entry struct width helper.
- Sub-module trace_ram: DEPTH x (XLEN+32+NCH*XLEN) flop array, one synchronous write port, one asynchronous read port.
- Top holds FSM, pointers, count, cycle/post counters.

## Test plan
- Reset: rst_n low 2 cycles mid-capture -> state 0, count 0, rd_valid 0, done 0, timeout 0.
- FILL: arm mode 0, 20 back-to-back captures pc=4*i -> count stops at 16; readout pc 0x00..0x3C in order, rd_last on 16th, done=1.
- WRAP: arm mode 1, 40 captures pc=4*i, trigger with i=30 -> stops after i=38; readout 16 entries pc 0x5C..0x98, cap_ch matches per entry.
- Timeout: arm, cap_valid low -> after 400 CAPTURE cycles timeout=1, count 0, DONE next cycle, rd_valid never high.
- Backpressure: full FILL buffer, rd_ready toggling each cycle -> data stable when stalled, exactly 16 transfers, no duplicates.
- Reset mid-readout after 5 transfers -> IDLE, count 0; re-arm mode 0 with 16 captures drains correctly.
